// File: rtl/bag_queue_if.sv
// Handshake bundle between the random source / game FSM and the 7-bag look-ahead queue.
interface bag_queue_if #(
  parameter int PIECE_W = 3,
  parameter int PREVIEW = 3
);
  logic                       flush;
  logic                       rnd_valid;
  logic [PIECE_W-1:0]         rnd;
  logic                       rnd_ready;
  logic                       pop;
  logic                       piece_valid;
  logic [PIECE_W-1:0]         piece;
  logic [PREVIEW*PIECE_W-1:0] preview;
  logic [PREVIEW-1:0]         preview_valid;
  logic [7:0]                 bag_count;

  modport master (
    output flush, rnd_valid, rnd, pop,
    input  rnd_ready, piece_valid, piece, preview, preview_valid, bag_count
  );

  modport slave (
    input  flush, rnd_valid, rnd, pop,
    output rnd_ready, piece_valid, piece, preview, preview_valid, bag_count
  );
endinterface

// File: rtl/bag_queue.sv
// 7-bag piece randomiser feeding a look-ahead FIFO with head + preview outputs.
// Optional BAG_LAST_FILL_EN: the last missing piece of a bag is pushed without waiting on rnd.
module bag_queue #(
  parameter int NUM_PIECES = 7,
  parameter int PIECE_W    = 3,
  parameter int QDEPTH     = 8,
  parameter int PREVIEW    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  bag_queue_if.slave bus
);
  localparam int PTR_W = $clog2(QDEPTH);

  logic [PIECE_W-1:0]    mem [QDEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;
  logic [NUM_PIECES-1:0] flags;
  logic [7:0]            bag_cnt;

  logic                  full, do_pop, take, accept, fill, push;
  logic [NUM_PIECES-1:0] rnd_mask, push_mask, next_flags;
  logic [PIECE_W-1:0]    fill_id, push_id;

  assign full = (count == (PTR_W+1)'(QDEPTH));

  // Out-of-range values produce an all-zero mask, so they are rejected like repeats.
  always_comb begin
    rnd_mask = '0;
    for (int i = 0; i < NUM_PIECES; i++)
      rnd_mask[i] = (bus.rnd == PIECE_W'(i));
  end

`ifdef BAG_LAST_FILL_EN
  assign fill = $onehot(~flags) && !full && !bus.flush;
  always_comb begin
    fill_id = '0;
    for (int i = 0; i < NUM_PIECES; i++)
      if (!flags[i]) fill_id = PIECE_W'(i);
  end
`else
  assign fill    = 1'b0;
  assign fill_id = '0;
`endif

  assign bus.rnd_ready = reset_n && !full && !bus.flush && !fill;
  assign take          = bus.rnd_valid && bus.rnd_ready;
  assign accept        = take && (|rnd_mask) && !(|(rnd_mask & flags));
  assign push          = accept || fill;
  assign push_id       = fill ? fill_id : bus.rnd;
  assign do_pop        = bus.pop && (count != '0) && !bus.flush;

  always_comb begin
    push_mask = '0;
    for (int i = 0; i < NUM_PIECES; i++)
      push_mask[i] = push && (push_id == PIECE_W'(i));
  end
  assign next_flags = flags | push_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      flags   <= '0;
      bag_cnt <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      flags   <= '0;
      bag_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Completing the bag clears every flag on the same edge so the next draw starts a fresh bag.
      if (push) begin
        if (&next_flags) begin
          flags   <= '0;
          bag_cnt <= bag_cnt + 8'd1;
        end else begin
          flags   <= next_flags;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  // Head and preview are read from registered state only; empty slots drive zero.
  always_comb begin
    bus.piece_valid   = (count != '0);
    bus.piece         = bus.piece_valid ? mem[rd_ptr] : '0;
    bus.preview       = '0;
    bus.preview_valid = '0;
    for (int k = 0; k < PREVIEW; k++) begin
      if (count > (PTR_W+1)'(k + 1)) begin
        bus.preview_valid[k]                  = 1'b1;
        bus.preview[k*PIECE_W +: PIECE_W]     = mem[rd_ptr + PTR_W'(k + 1)];
      end
    end
  end

  assign bus.bag_count = bag_cnt;
endmodule

// File: tb/tb_bag_queue.sv
// Directed bench for bag_queue: draws, rejection, bag rollover, full queue, pop/push, flush.
module tb_bag_queue;
  logic clk = 1'b0;
  logic reset_n;
  logic rdy;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bag_queue_if #(.PIECE_W(3), .PREVIEW(3)) bus ();

  bag_queue #(.NUM_PIECES(7), .PIECE_W(3), .QDEPTH(8), .PREVIEW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive one cycle of inputs, capture rnd_ready before the edge, sample state after it.
  task automatic cyc(input logic v, input logic [2:0] r, input logic p, input logic f);
    bus.rnd_valid = v;
    bus.rnd       = r;
    bus.pop       = p;
    bus.flush     = f;
    #1 rdy = bus.rnd_ready;
    @(posedge clk);
    #1;
    bus.rnd_valid = 1'b0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.rnd_valid = 1'b0;
    bus.rnd       = '0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    #12;
    chk("rst_ready", bus.rnd_ready, 0);
    chk("rst_valid", bus.piece_valid, 0);
    chk("rst_piece", bus.piece, 0);
    chk("rst_prev", bus.preview, 0);
    chk("rst_pvld", bus.preview_valid, 0);
    chk("rst_bag", bus.bag_count, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // 3 accepted, 3 repeat rejected, 7 out of range rejected, 0 accepted
    cyc(1, 3'd3, 0, 0); chk("t1_rdy0", rdy, 1);
    chk("t1_lat_valid", bus.piece_valid, 1);
    chk("t1_lat_piece", bus.piece, 3);
    cyc(1, 3'd3, 0, 0); chk("t1_rdy1", rdy, 1);
    cyc(1, 3'd7, 0, 0); chk("t1_rdy2", rdy, 1);
    cyc(1, 3'd0, 0, 0); chk("t1_rdy3", rdy, 1);
    chk("t1_piece", bus.piece, 3);
    chk("t1_slot0", bus.preview[2:0], 0);
    chk("t1_pvld", bus.preview_valid, 3'b001);

    // New game, then a full bag 0..6 rolls bag_count
    cyc(0, 3'd0, 0, 1); chk("flush_rdy", rdy, 0);
    chk("flush_empty", bus.piece_valid, 0);
    for (int i = 0; i < 6; i++) cyc(1, 3'(i), 0, 0);
    chk("t2_bag_before", bus.bag_count, 0);
    cyc(1, 3'd6, 0, 0);
    chk("t2_bag_after", bus.bag_count, 1);
    cyc(1, 3'd0, 0, 0); chk("t2_rdy_newbag", rdy, 1);
    chk("t2_piece", bus.piece, 0);
    chk("t2_prev", bus.preview, {3'd3, 3'd2, 3'd1});
    chk("t2_pvld", bus.preview_valid, 3'b111);

    // Queue now full (0..6,0): rnd=5 must not enter
    cyc(1, 3'd5, 0, 0); chk("t3_full_rdy", rdy, 0);
    chk("t3_full_piece", bus.piece, 0);
    chk("t3_full_prev", bus.preview, {3'd3, 3'd2, 3'd1});
    cyc(0, 3'd0, 1, 0);
    chk("t3_pop_piece", bus.piece, 1);
    cyc(1, 3'd5, 0, 0); chk("t3_rdy_after_pop", rdy, 1);
    cyc(0, 3'd0, 0, 0); chk("t3_full_again", rdy, 0);

    // Queue 1,2,3,4,5,6,0,5: pop down to 0,5
    for (int i = 0; i < 6; i++) cyc(0, 3'd0, 1, 0);
    chk("t4_piece", bus.piece, 0);
    chk("t4_slot0", bus.preview[2:0], 5);
    chk("t4_pvld", bus.preview_valid, 3'b001);
    cyc(1, 3'd3, 1, 0);
    chk("t4_pp_piece", bus.piece, 5);
    chk("t4_pp_slot0", bus.preview[2:0], 3);
    chk("t4_pp_pvld", bus.preview_valid, 3'b001);

    // Queue 5,3 -> add 1,2 -> 4 queued, then flush mid-bag
    cyc(1, 3'd1, 0, 0);
    cyc(1, 3'd2, 0, 0);
    chk("t5_pvld4", bus.preview_valid, 3'b111);
    chk("t5_prev", bus.preview, {3'd2, 3'd1, 3'd3});
    cyc(1, 3'd4, 1, 1); chk("t5_flush_rdy", rdy, 0);
    chk("t5_valid", bus.piece_valid, 0);
    chk("t5_bag", bus.bag_count, 0);
    chk("t5_pvld", bus.preview_valid, 0);
    cyc(1, 3'd2, 0, 0); chk("t5_rdy", rdy, 1);
    chk("t5_piece", bus.piece, 2);
    cyc(1, 3'd0, 0, 0);
    chk("t5_slot0", bus.preview[2:0], 0);

    // Last-piece behaviour: feed 6..1
    cyc(0, 3'd0, 0, 1);
    for (int i = 6; i >= 1; i--) cyc(1, 3'(i), 0, 0);
    chk("t6_bag_open", bus.bag_count, 0);
    chk("t6_piece", bus.piece, 6);
`ifdef BAG_LAST_FILL_EN
    cyc(0, 3'd0, 0, 0); chk("t6_fill_rdy", rdy, 0);
    chk("t6_fill_bag", bus.bag_count, 1);
    cyc(0, 3'd0, 0, 0); chk("t6_rdy_after", rdy, 1);
`else
    cyc(0, 3'd0, 0, 0); chk("t6_idle_rdy", rdy, 1);
    chk("t6_still_open", bus.bag_count, 0);
    cyc(1, 3'd0, 0, 0); chk("t6_last_rdy", rdy, 1);
    chk("t6_bag_done", bus.bag_count, 1);
`endif
    chk("t6_prev", bus.preview, {3'd3, 3'd4, 3'd5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bag_queue.md
Name: bag_queue

Overview:
- Parametrised 7-bag randomiser with look-ahead queue for the Tetris controller.
- Consumes raw values from the random source. Rejects out-of-range values and pieces already drawn in the current bag. Pushes accepted pieces into a FIFO.
- Exposes the head piece and a preview window to the game FSM and renderer.
- Starts the next bag automatically, so the preview is continuous across bag boundaries.

Parameters:
- NUM_PIECES, 7, distinct piece IDs per bag (IDs 0..NUM_PIECES-1), 2..16.
- PIECE_W, 3, bits per piece ID; 2**PIECE_W must be >= NUM_PIECES.
- QDEPTH, 8, FIFO entries, power of two, >= PREVIEW+1.
- PREVIEW, 3, preview slots exported after the head.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of queue and bag state (new game).
- rnd_valid  in  1  random source presents a value.
- rnd  in  PIECE_W  raw random value.
- rnd_ready  out  1  value consumed this cycle when rnd_valid & rnd_ready.
- pop  in  1  consume head piece.
- piece_valid  out  1  queue non-empty.
- piece  out  PIECE_W  head piece ID (0 when empty).
- preview  out  PREVIEW*PIECE_W  slot k at bits [(k+1)*PIECE_W-1 : k*PIECE_W]; slot 0 is the entry after the head.
- preview_valid  out  PREVIEW  bit k set when slot k holds a queued piece.
- bag_count  out  8  bags completed since reset/flush, wraps 255->0.

Behaviour:
- Clock and reset: single clock, clk. Asynchronous active-low reset reset_n, applied on its negedge and held while low.
- Reset values:
  - FIFO empty; flags 0; bag_count 0.
  - piece_valid 0, piece 0, preview 0, preview_valid 0.
  - rnd_ready 0 while reset_n low.
- Priority: reset_n > flush > normal operation.
- flush cycle:
  - Clears FIFO, flags and bag_count.
  - pop and rnd are ignored.
  - rnd_ready is 0 during flush.
- rnd_ready = !full & !flush, where full uses the registered count (count == QDEPTH). No pop-through when full.
- On rnd_valid & rnd_ready, the value is always consumed. It is accepted only if rnd < NUM_PIECES and flags[rnd] == 0.
- Accepted value:
  - Same edge: flags[rnd] <= 1 and the piece is written at the tail.
  - Visible at head/preview the next cycle.
- Rejected value: discarded; no state change.
- Bag completion: when an accepted piece sets the last clear flag, all flags clear on the same edge and bag_count increments. The next cycle draws a new bag. Zero dead cycles.
- Latency: 1 cycle from rnd accept to piece_valid.
- Pop:
  - pop & piece_valid advances the head on the edge.
  - pop on empty is ignored.
  - Simultaneous push and pop: count unchanged, both take effect.
- Pointers: read/write pointers log2(QDEPTH) bits, wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits.
- Preview: slot k = entry at rd_ptr+1+k (mod QDEPTH). preview_valid[k] = count > k+1. Invalid slots drive 0.
- Outputs are combinational from registered state only. There is no combinational path from pop or rnd to piece or preview.

Optional Feature:
- Macro: BAG_LAST_FILL_EN.
- Defined:
  - When exactly one flag is clear and the FIFO is not full, the missing piece is pushed without consuming rnd; rnd_ready is 0 that cycle.
  - The bag then completes as usual.
  - Bounds bag fill time to NUM_PIECES-1 accepted draws.
- Undefined: the last piece is only obtained through rnd like any other.

Test Plan:
- Reset, then drive rnd 3,3,7,0 with rnd_valid=1, pop=0. Expect:
  - rnd_ready=1 each cycle.
  - Accepted 3 and 0; second 3 and 7 rejected.
  - piece=3, preview slot0=0, preview_valid=001.
- Feed 0..6 in order. Expect:
  - bag_count 0->1 on the 7th accept.
  - A subsequent rnd 0 is accepted immediately.
  - piece=0, preview=1,2,3.
- Fill 8 entries with no pop. Expect:
  - rnd_ready=0; rnd_valid held with rnd=5 causes no change.
  - One pop, then rnd_ready=1 next cycle and 5 accepted if its flag is clear.
- Queue holds 2 pieces; pop and accept a new piece in the same cycle. Expect count stays 2 and head advances.
- Mid-bag flush with 4 queued. Expect:
  - Next cycle piece_valid=0, bag_count=0, flags clear.
  - rnd 2 previously drawn is accepted.
- With BAG_LAST_FILL_EN defined, feed 6,5,4,3,2,1. Expect:
  - Piece 0 is pushed the next cycle with rnd_ready=0.
  - bag_count increments.
- Without the macro, the bag stays open until rnd=0 arrives.
